sdram_writer: RTL and testbench

Avalon-MM burst write master that drains 64-bit pixel words (8 px/word) from a show-ahead FIFO and writes them as a linear frame into SDRAM. It is the producer side of the frame buffer whose consumer is the SDRAM read path. After each complete frame it pulses frame_done_o. It raises a sticky frame_ready_o so the read path may begin fetching. Single clock domain (sdram_clk); the upstream FIFO performs any clock crossing.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_writer_if.sv | 38 +++
 rtl/sdram_writer.sv | 152 +++++++++++++++
 tb/tb_sdram_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM frame-buffer write and read paths.
//   state_t          : writer FSM encoding (IDLE, ARM, BURST)
//   SDRAM_DATA_W     : Avalon data width (one word = 8 pixels)
//   SDRAM_BE_W       : Avalon byteenable width
//   SDRAM_BURST_W    : Avalon burstcount width
//   DEF_FRAME_WORDS  : 64-bit words in a 1920x1080 frame
//   DEF_BURST_LEN    : default words per full burst
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int SDRAM_DATA_W    = 64;
    localparam int SDRAM_BE_W      = 8;
    localparam int SDRAM_BURST_W   = 8;
    localparam int DEF_FRAME_WORDS = 259200;
    localparam int DEF_BURST_LEN   = 16;

endpackage

// File: rtl/sdram_writer_if.sv
// Bus bundle between the frame writer, its show-ahead pixel FIFO and the
// Avalon-MM SDRAM slave.
//   pix_data_i / pix_usedw_i / pix_rdreq_o : FIFO head word, fill level, pop
//   sdram_*                                : Avalon-MM burst write master
// Handshake: a beat transfers on every cycle where sdram_write_o is high and
// sdram_waitrequest_i is low; pix_rdreq_o is high on exactly those cycles, so
// the FIFO pops the word that was just accepted and presents the next one.
// While waitrequest is high every master output, including writedata, holds.
interface sdram_writer_if
#(
    parameter int ADDR_W  = 29,
    parameter int USEDW_W = 9
);
    import sdram_pkg::*;

    logic [SDRAM_DATA_W-1:0]  pix_data_i;
    logic [USEDW_W-1:0]       pix_usedw_i;
    logic                     pix_rdreq_o;
    logic [ADDR_W-1:0]        sdram_address_o;
    logic [SDRAM_BURST_W-1:0] sdram_burstcount_o;
    logic                     sdram_write_o;
    logic [SDRAM_DATA_W-1:0]  sdram_writedata_o;
    logic [SDRAM_BE_W-1:0]    sdram_byteenable_o;
    logic                     sdram_waitrequest_i;

    modport master (
        input  pix_data_i, pix_usedw_i, sdram_waitrequest_i,
        output pix_rdreq_o, sdram_address_o, sdram_burstcount_o,
               sdram_write_o, sdram_writedata_o, sdram_byteenable_o
    );

    modport slave (
        output pix_data_i, pix_usedw_i, sdram_waitrequest_i,
        input  pix_rdreq_o, sdram_address_o, sdram_burstcount_o,
               sdram_write_o, sdram_writedata_o, sdram_byteenable_o
    );

endinterface

// File: rtl/sdram_writer.sv
// Avalon-MM burst write master: drains 64-bit pixel words from a show-ahead
// FIFO and writes them as one linear frame starting at BASE_ADDR, then wraps.
// Ports:
//   sdram_clk, rst   : clock, asynchronous active-high reset
//   enable_i         : allow new bursts (sampled at burst boundaries only)
//   bus (master)     : FIFO pop side plus Avalon-MM write master
//   frame_done_o     : one-cycle pulse after the last word of a frame
//   frame_ready_o    : sticky, set after the first complete frame
//   state_dbg_o      : current FSM state
module sdram_writer
    import sdram_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 29,
    parameter int USEDW_W     = 9
)(
    input  logic           sdram_clk,
    input  logic           rst,
    input  logic           enable_i,
    sdram_writer_if.master bus,
    output logic           frame_done_o,
    output logic           frame_ready_o,
    output state_t         state_dbg_o
);

    localparam int WW_W = $clog2(FRAME_WORDS + 1);

    state_t                   state_q, state_d;
    logic [WW_W-1:0]          words_q, words_d;
    logic [SDRAM_BURST_W-1:0] beats_q, beats_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [SDRAM_BURST_W-1:0] bc_q, bc_d;
    logic                     write_q, write_d;
    logic                     done_q, done_d;
    logic                     ready_q, ready_d;

    logic                     accept;
    logic                     last_beat;
    logic                     frame_end;
    logic                     start_ok;
    logic [31:0]              remaining;
    logic [31:0]              blen32;
    logic [SDRAM_BURST_W-1:0] blen;

    assign accept    = write_q & ~bus.sdram_waitrequest_i;
    assign last_beat = accept && (beats_q == SDRAM_BURST_W'(1));
    // Only true on the final beat of the tail burst of a frame.
    assign frame_end = accept && (words_q == WW_W'(FRAME_WORDS - 1));

    assign bus.pix_rdreq_o        = accept;
    assign bus.sdram_writedata_o  = bus.pix_data_i;
    assign bus.sdram_byteenable_o = {SDRAM_BE_W{1'b1}};
    assign bus.sdram_address_o    = addr_q;
    assign bus.sdram_burstcount_o = bc_q;
    assign bus.sdram_write_o      = write_q;
    assign frame_done_o           = done_q;
    assign frame_ready_o          = ready_q;
    assign state_dbg_o            = state_q;

    // Length of the next burst: a full burst, or the shorter frame tail.
    // A burst only starts once the FIFO already holds every word of it, so
    // write never has to drop mid-burst for lack of data.
    always_comb begin
        remaining = 32'(FRAME_WORDS) - 32'(words_q);
        blen32    = (remaining < 32'(BURST_LEN)) ? remaining : 32'(BURST_LEN);
        blen      = SDRAM_BURST_W'(blen32);
        start_ok  = (32'(bus.pix_usedw_i) >= blen32);
    end

    // State and output registers.
    always_ff @(posedge sdram_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            words_q <= '0;
            beats_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            bc_q    <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            beats_q <= beats_d;
            addr_q  <= addr_d;
            bc_q    <= bc_d;
            write_q <= write_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Next state. A running burst always finishes (Avalon cannot abort a
    // burst); enable_i only decides where to go once it has.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = ARM;
            end
            ARM: begin
                if (!enable_i)     state_d = IDLE;
                else if (start_ok) state_d = BURST;
            end
            BURST: begin
                if (last_beat) state_d = enable_i ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        words_d = words_q;
        beats_d = beats_q;
        addr_d  = addr_q;
        bc_d    = bc_q;
        write_d = write_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        unique case (state_q)
            ARM: begin
                if (enable_i && start_ok) begin
                    write_d = 1'b1;
                    bc_d    = blen;
                    beats_d = blen;
                    addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(words_q);
                end
            end
            BURST: begin
                if (accept) begin
                    beats_d = beats_q - SDRAM_BURST_W'(1);
                    if (frame_end) begin
                        words_d = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        words_d = words_q + WW_W'(1);
                    end
                    if (last_beat) begin
                        write_d = 1'b0;
                        bc_d    = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_writer.sv
module tb_sdram_writer;
    import sdram_pkg::*;

    logic   sdram_clk;
    logic   rst;
    logic   en_a, en_b;
    logic   done_a, done_b, ready_a, ready_b;
    state_t state_a, state_b;

    int vectors    = 0;
    int miscompares = 0;

    // FIFO models: level = pushed - head; head advances on every pop.
    int pushed_a = 0, head_a = 0;
    int pushed_b = 0, head_b = 0;

    sdram_writer_if #(.ADDR_W(29), .USEDW_W(9)) if_a ();
    sdram_writer_if #(.ADDR_W(29), .USEDW_W(9)) if_b ();

    // dut_a: 32-word frame (two full bursts); dut_b: 40-word frame (16/16/8).
    sdram_writer #(.BURST_LEN(16), .FRAME_WORDS(32), .BASE_ADDR(0), .ADDR_W(29), .USEDW_W(9)) dut_a (
        .sdram_clk(sdram_clk), .rst(rst), .enable_i(en_a), .bus(if_a),
        .frame_done_o(done_a), .frame_ready_o(ready_a), .state_dbg_o(state_a)
    );
    sdram_writer #(.BURST_LEN(16), .FRAME_WORDS(40), .BASE_ADDR(0), .ADDR_W(29), .USEDW_W(9)) dut_b (
        .sdram_clk(sdram_clk), .rst(rst), .enable_i(en_b), .bus(if_b),
        .frame_done_o(done_b), .frame_ready_o(ready_b), .state_dbg_o(state_b)
    );

    function automatic logic [63:0] pattern(input int k);
        return {32'(k) ^ 32'hC0DE_F00D, 32'(k) + 32'h1000_0000};
    endfunction

    function automatic logic [8:0] level(input int n);
        if (n <= 0)  return 9'd0;
        if (n > 511) return 9'h1FF;
        return 9'(n);
    endfunction

    assign if_a.pix_data_i  = pattern(head_a);
    assign if_a.pix_usedw_i = level(pushed_a - head_a);
    assign if_b.pix_data_i  = pattern(head_b);
    assign if_b.pix_usedw_i = level(pushed_b - head_b);

    always @(posedge sdram_clk) if (if_a.pix_rdreq_o === 1'b1) head_a <= head_a + 1;
    always @(posedge sdram_clk) if (if_b.pix_rdreq_o === 1'b1) head_b <= head_b + 1;

    // clock / reset
    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want summary earlier");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        @(negedge sdram_clk);
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        if_a.sdram_waitrequest_i = 1'b0; if_b.sdram_waitrequest_i = 1'b0;
        @(negedge sdram_clk);
        pushed_a = head_a; pushed_b = head_b;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        if_a.sdram_waitrequest_i = 1'b0; if_b.sdram_waitrequest_i = 1'b0;
        pushed_a = 64; pushed_b = 64;
        repeat (2) @(negedge sdram_clk);
        vectors++;
        if (if_a.sdram_write_o !== 1'b0 || if_b.sdram_write_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_write: got %b/%b want 0/0", if_a.sdram_write_o, if_b.sdram_write_o);
        end
        vectors++;
        if (if_a.sdram_address_o !== 29'd0 || if_a.sdram_burstcount_o !== 8'd0) begin
            miscompares++; $display("FAIL reset_addr_bc: got %0d/%0d want 0/0", if_a.sdram_address_o, if_a.sdram_burstcount_o);
        end
        vectors++;
        if (done_a !== 1'b0 || ready_a !== 1'b0 || ready_b !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got done=%b ready=%b/%b want 0", done_a, ready_a, ready_b);
        end
        vectors++;
        if (if_a.pix_rdreq_o !== 1'b0 || state_a !== IDLE) begin
            miscompares++; $display("FAIL reset_rdreq_state: got %b/%0d want 0/IDLE", if_a.pix_rdreq_o, state_a);
        end
        vectors++;
        if (if_a.sdram_byteenable_o !== 8'hFF) begin
            miscompares++; $display("FAIL byteenable: got %h want ff", if_a.sdram_byteenable_o);
        end
        pushed_a = 0; pushed_b = 0;
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int hs;
        int idx;
        logic exp_w;
        logic [28:0] exp_addr;
        @(negedge sdram_clk);
        hs = head_a;
        pushed_a = head_a + 32;
        en_a = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge sdram_clk);
            exp_w    = (c >= 2 && c <= 17) || (c >= 19 && c <= 34);
            exp_addr = (c <= 17) ? 29'd0 : 29'd16;
            idx      = (c <= 17) ? c - 2 : c - 3;
            vectors++;
            if (if_a.sdram_write_o !== exp_w) begin
                miscompares++; $display("FAIL frame_write c=%0d: got %b want %b", c, if_a.sdram_write_o, exp_w);
            end
            vectors++;
            if (if_a.sdram_burstcount_o !== (exp_w ? 8'd16 : 8'd0)) begin
                miscompares++; $display("FAIL frame_bc c=%0d: got %0d want %0d", c, if_a.sdram_burstcount_o, exp_w ? 16 : 0);
            end
            if (exp_w) begin
                vectors++;
                if (if_a.sdram_address_o !== exp_addr || if_a.sdram_writedata_o !== pattern(hs + idx)) begin
                    miscompares++; $display("FAIL frame_addr_data c=%0d: got %0d/%h want %0d/%h", c,
                        if_a.sdram_address_o, if_a.sdram_writedata_o, exp_addr, pattern(hs + idx));
                end
            end
            vectors++;
            if (done_a !== (c == 35) || ready_a !== (c >= 35)) begin
                miscompares++; $display("FAIL frame_done_ready c=%0d: got %b/%b want %b/%b", c, done_a, ready_a, c == 35, c >= 35);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_tail_and_wrap();
        int hs;
        int idx;
        logic exp_w;
        logic [28:0] exp_addr;
        logic [7:0] exp_bc;
        @(negedge sdram_clk);
        hs = head_b;
        pushed_b = head_b + 80;
        en_b = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge sdram_clk);
            exp_w = (c >= 2 && c <= 17) || (c >= 19 && c <= 34) || (c >= 36 && c <= 43) || (c >= 45);
            if (c <= 17)      begin exp_addr = 29'd0;  idx = c - 2; end
            else if (c <= 34) begin exp_addr = 29'd16; idx = c - 3; end
            else if (c <= 43) begin exp_addr = 29'd32; idx = c - 4; end
            else              begin exp_addr = 29'd0;  idx = c - 5; end
            exp_bc = !exp_w ? 8'd0 : (c >= 36 && c <= 43) ? 8'd8 : 8'd16;
            vectors++;
            if (if_b.sdram_write_o !== exp_w || if_b.sdram_burstcount_o !== exp_bc) begin
                miscompares++; $display("FAIL tail_write_bc c=%0d: got %b/%0d want %b/%0d", c,
                    if_b.sdram_write_o, if_b.sdram_burstcount_o, exp_w, exp_bc);
            end
            if (exp_w) begin
                vectors++;
                if (if_b.sdram_address_o !== exp_addr || if_b.sdram_writedata_o !== pattern(hs + idx)) begin
                    miscompares++; $display("FAIL tail_addr_data c=%0d: got %0d/%h want %0d/%h", c,
                        if_b.sdram_address_o, if_b.sdram_writedata_o, exp_addr, pattern(hs + idx));
                end
            end
            vectors++;
            if (done_b !== (c == 44) || ready_b !== (c >= 44)) begin
                miscompares++; $display("FAIL tail_done_ready c=%0d: got %b/%b want %b/%b", c, done_b, ready_b, c == 44, c >= 44);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int acc = 0;
        int hs;
        int guard = 0;
        @(negedge sdram_clk);
        vectors++;
        if (ready_a !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset_ready: got %b want 1", ready_a);
        end
        hs = head_a;
        pushed_a = head_a + 16;
        en_a = 1'b1;
        while (acc < 8 && guard < 40) begin
            @(negedge sdram_clk);
            guard++;
            if (if_a.sdram_write_o === 1'b1 && acc < 8) acc++;
        end
        @(negedge sdram_clk);
        vectors++;
        if (acc != 8 || head_a - hs != 8 || if_a.sdram_write_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_setup: got beats=%0d write=%b want 8/1", head_a - hs, if_a.sdram_write_o);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (if_a.sdram_write_o !== 1'b0 || if_a.pix_rdreq_o !== 1'b0 || if_a.sdram_burstcount_o !== 8'd0) begin
            miscompares++; $display("FAIL rst_async_outputs: got write=%b rdreq=%b bc=%0d want 0/0/0",
                if_a.sdram_write_o, if_a.pix_rdreq_o, if_a.sdram_burstcount_o);
        end
        vectors++;
        if (if_a.sdram_address_o !== 29'd0 || ready_a !== 1'b0 || state_a !== IDLE) begin
            miscompares++; $display("FAIL rst_async_state: got addr=%0d ready=%b state=%0d want 0/0/IDLE",
                if_a.sdram_address_o, ready_a, state_a);
        end
        @(negedge sdram_clk);
        rst = 1'b0;
        pushed_a = head_a + 16;
        guard = 0;
        while (if_a.sdram_write_o !== 1'b1 && guard < 10) begin
            @(negedge sdram_clk);
            guard++;
        end
        vectors++;
        if (if_a.sdram_write_o !== 1'b1 || if_a.sdram_address_o !== 29'd0 || if_a.sdram_burstcount_o !== 8'd16 || ready_a !== 1'b0) begin
            miscompares++; $display("FAIL rst_restart: got write=%b addr=%0d bc=%0d ready=%b want 1/0/16/0",
                if_a.sdram_write_o, if_a.sdram_address_o, if_a.sdram_burstcount_o, ready_a);
        end
        en_a = 1'b0;
        guard = 0;
        while (if_a.sdram_write_o === 1'b1 && guard < 30) begin
            @(negedge sdram_clk);
            guard++;
        end
    endtask

    task automatic test_usedw_threshold();
        int run = 0;
        int guard = 0;
        reset_dut();
        pushed_b = head_b + 15;
        en_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge sdram_clk);
            vectors++;
            if (if_b.sdram_write_o !== 1'b0) begin
                miscompares++; $display("FAIL usedw15_write c=%0d: got %b want 0", c, if_b.sdram_write_o);
            end
        end
        vectors++;
        if (state_b !== ARM) begin
            miscompares++; $display("FAIL usedw15_state: got %0d want ARM", state_b);
        end
        pushed_b = head_b + 16;
        @(negedge sdram_clk);
        vectors++;
        if (if_b.sdram_write_o !== 1'b1 || if_b.sdram_address_o !== 29'd0 || if_b.sdram_burstcount_o !== 8'd16) begin
            miscompares++; $display("FAIL usedw16_start: got write=%b addr=%0d bc=%0d want 1/0/16",
                if_b.sdram_write_o, if_b.sdram_address_o, if_b.sdram_burstcount_o);
        end
        en_b = 1'b0;
        while (if_b.sdram_write_o === 1'b1 && guard < 40) begin
            run++;
            @(negedge sdram_clk);
            guard++;
        end
        vectors++;
        if (run != 16) begin
            miscompares++; $display("FAIL usedw16_run: got %0d write cycles want 16", run);
        end
    endtask

    task automatic test_waitrequest_stall();
        logic [39:0] wpat = 40'b1011_0011_1000_1101_0110_0111_0001_1010_1100_1001;
        logic [63:0] s_data;
        logic [28:0] s_addr;
        logic [7:0]  s_bc;
        logic        stalled = 1'b0;
        int acc = 0;
        int hs;
        int i = 0;
        reset_dut();
        hs = head_b;
        pushed_b = head_b + 16;
        en_b = 1'b1;
        while (acc < 16 && i < 120) begin
            @(negedge sdram_clk);
            if (stalled) begin
                vectors++;
                if (if_b.sdram_writedata_o !== s_data || if_b.sdram_address_o !== s_addr || if_b.sdram_burstcount_o !== s_bc) begin
                    miscompares++; $display("FAIL stall_hold i=%0d: got %h/%0d/%0d want %h/%0d/%0d", i,
                        if_b.sdram_writedata_o, if_b.sdram_address_o, if_b.sdram_burstcount_o, s_data, s_addr, s_bc);
                end
            end
            if_b.sdram_waitrequest_i = wpat[i % 40];
            stalled = 1'b0;
            if (if_b.sdram_write_o === 1'b1) begin
                en_b = 1'b0;
                if (wpat[i % 40]) begin
                    stalled = 1'b1;
                    s_data = if_b.sdram_writedata_o; s_addr = if_b.sdram_address_o; s_bc = if_b.sdram_burstcount_o;
                end else begin
                    vectors++;
                    if (if_b.sdram_writedata_o !== pattern(hs + acc)) begin
                        miscompares++; $display("FAIL stall_data beat=%0d: got %h want %h", acc, if_b.sdram_writedata_o, pattern(hs + acc));
                    end
                    acc++;
                end
            end
            i++;
        end
        @(negedge sdram_clk);
        if_b.sdram_waitrequest_i = 1'b0;
        vectors++;
        if (acc != 16 || head_b - hs != 16 || if_b.sdram_write_o !== 1'b0) begin
            miscompares++; $display("FAIL stall_count: got accepted=%0d pops=%0d write=%b want 16/16/0",
                acc, head_b - hs, if_b.sdram_write_o);
        end
    endtask

    task automatic test_enable_drop();
        int acc = 0;
        int guard = 0;
        logic seen = 1'b0;
        logic any_w = 1'b0;
        reset_dut();
        pushed_b = head_b + 32;
        en_b = 1'b1;
        while (guard < 60 && !(seen && if_b.sdram_write_o !== 1'b1)) begin
            @(negedge sdram_clk);
            guard++;
            if (if_b.sdram_write_o === 1'b1) begin
                seen = 1'b1;
                acc++;
                if (acc == 5) en_b = 1'b0;
            end
        end
        vectors++;
        if (acc != 16) begin
            miscompares++; $display("FAIL endrop_beats: got %0d want 16", acc);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge sdram_clk);
            if (if_b.sdram_write_o !== 1'b0) any_w = 1'b1;
        end
        vectors++;
        if (any_w || state_b !== IDLE) begin
            miscompares++; $display("FAIL endrop_idle: got write_seen=%b state=%0d want 0/IDLE", any_w, state_b);
        end
        en_b = 1'b1;
        guard = 0;
        while (if_b.sdram_write_o !== 1'b1 && guard < 10) begin
            @(negedge sdram_clk);
            guard++;
        end
        vectors++;
        if (if_b.sdram_write_o !== 1'b1 || if_b.sdram_address_o !== 29'd16 || if_b.sdram_burstcount_o !== 8'd16) begin
            miscompares++; $display("FAIL endrop_resume: got write=%b addr=%0d bc=%0d want 1/16/16",
                if_b.sdram_write_o, if_b.sdram_address_o, if_b.sdram_burstcount_o);
        end
        en_b = 1'b0;
        guard = 0;
        while (if_b.sdram_write_o === 1'b1 && guard < 30) begin
            @(negedge sdram_clk);
            guard++;
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_tail_and_wrap();
        test_reset_mid_burst();
        test_usedw_threshold();
        test_waitrequest_stall();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
